// File: rtl/pc_sequencer.sv
// Multi-cycle instruction sequencer: owns the program counter and walks each
// instruction through fetch, decode, execute and writeback with stall and halt.
module pc_sequencer #(
  parameter int ADDR_W = 6,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stall,
  input  logic              imem_ready,
  input  logic              is_halt,
  input  logic              alu_busy,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] pc,
  output logic              imem_req,
  output logic              ir_load,
  output logic              dec_en,
  output logic              exec_en,
  output logic              wb_en,
  output logic              halted,
  output logic [CNT_W-1:0]  retired
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    DECODE    = 3'd2,
    EXECUTE   = 3'd3,
    WRITEBACK = 3'd4,
    HALTED    = 3'd5
  } state_t;

  state_t              state;
  state_t              next_state;
  logic [ADDR_W-1:0]   next_pc;
  logic [CNT_W-1:0]    next_retired;

  // State, program counter and retired-instruction counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      pc      <= {ADDR_W{1'b0}};
      retired <= {CNT_W{1'b0}};
    end else begin
      state   <= next_state;
      pc      <= next_pc;
      retired <= next_retired;
    end
  end

  // Next-state, PC/counter update and stage strobes; stall freezes the
  // active stages and masks every strobe except halted
  always_comb begin
    next_state   = state;
    next_pc      = pc;
    next_retired = retired;
    imem_req     = 1'b0;
    ir_load      = 1'b0;
    dec_en       = 1'b0;
    exec_en      = 1'b0;
    wb_en        = 1'b0;
    halted       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = FETCH;
        end else begin
          next_state = IDLE;
        end
      end
      FETCH: begin
        if (!stall) begin
          imem_req = 1'b1;
          if (imem_ready) begin
            ir_load    = 1'b1;
            next_state = DECODE;
          end else begin
            next_state = FETCH;
          end
        end else begin
          next_state = FETCH;
        end
      end
      DECODE: begin
        if (!stall) begin
          dec_en = 1'b1;
          if (is_halt) begin
            next_state = HALTED;
          end else begin
            next_state = EXECUTE;
          end
        end else begin
          next_state = DECODE;
        end
      end
      EXECUTE: begin
        if (!stall) begin
          exec_en = 1'b1;
          if (alu_busy) begin
            next_state = EXECUTE;
          end else begin
            next_state = WRITEBACK;
          end
        end else begin
          next_state = EXECUTE;
        end
      end
      WRITEBACK: begin
        if (!stall) begin
          wb_en        = 1'b1;
          next_state   = FETCH;
          next_retired = retired + {{(CNT_W-1){1'b0}}, 1'b1};
          // jump outranks branch; the sequential increment wraps naturally
          if (jump) begin
            next_pc = jump_target;
          end else if (branch_taken) begin
            next_pc = branch_target;
          end else begin
            next_pc = pc + {{(ADDR_W-1){1'b0}}, 1'b1};
          end
        end else begin
          next_state = WRITEBACK;
        end
      end
      HALTED: begin
        halted = 1'b1;
        if (start) begin
          next_state = FETCH;
          next_pc    = {ADDR_W{1'b0}};
        end else begin
          next_state = HALTED;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer: sequencing, redirects, wrap,
// wait states, halt/restart, stall and asynchronous reset.
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, stall, imem_ready, is_halt, alu_busy, jump, branch_taken;
  logic [5:0] jump_target, branch_target;
  logic [5:0] pc;
  logic       imem_req, ir_load, dec_en, exec_en, wb_en, halted;
  logic [15:0] retired;
  logic [5:0] strb;
  int         cmps = 0;
  int         errs = 0;

  assign strb = {imem_req, ir_load, dec_en, exec_en, wb_en, halted};

  pc_sequencer #(.ADDR_W(6), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall),
    .imem_ready(imem_ready), .is_halt(is_halt), .alu_busy(alu_busy),
    .jump(jump), .jump_target(jump_target),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .pc(pc), .imem_req(imem_req), .ir_load(ir_load), .dec_en(dec_en),
    .exec_en(exec_en), .wb_en(wb_en), .halted(halted), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // From FETCH (imem_ready=1), run one instruction with the given redirect.
  task automatic run_instr(input logic j, input logic [5:0] jt,
                           input logic b, input logic [5:0] bt);
    step();
    step();
    step();
    jump = j; jump_target = jt; branch_taken = b; branch_target = bt;
    step();
    jump = 1'b0; branch_taken = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; stall = 1'b0; imem_ready = 1'b0; is_halt = 1'b0;
    alu_busy = 1'b0; jump = 1'b0; branch_taken = 1'b0;
    jump_target = 6'd0; branch_target = 6'd0;
    #2;
    cmps++; if (strb !== 6'b000000 || pc !== 6'd0 || retired !== 16'd0) begin errs++; $display("FAIL reset: strb=%b pc=%0d ret=%0d want 000000/0/0", strb, pc, retired); end
    @(negedge clk); rst = 1'b1;
    step();
    cmps++; if (strb !== 6'b000000) begin errs++; $display("FAIL idle_hold: strb=%b want 000000", strb); end
  endtask

  task automatic test_sequential();
    start = 1'b1; imem_ready = 1'b1;
    step();
    start = 1'b0;
    #1;
    cmps++; if (strb !== 6'b110000 || pc !== 6'd0) begin errs++; $display("FAIL first_fetch: strb=%b pc=%0d want 110000/0", strb, pc); end
    for (int i = 0; i < 3; i++) begin
      step();
      cmps++; if (strb !== 6'b001000) begin errs++; $display("FAIL seq_decode%0d: strb=%b want 001000", i, strb); end
      step();
      cmps++; if (strb !== 6'b000100) begin errs++; $display("FAIL seq_exec%0d: strb=%b want 000100", i, strb); end
      step();
      cmps++; if (strb !== 6'b000010 || retired !== 16'(i)) begin errs++; $display("FAIL seq_wb%0d: strb=%b ret=%0d want 000010/%0d", i, strb, retired, i); end
      step();
      cmps++; if (strb !== 6'b110000 || pc !== 6'(i + 1) || retired !== 16'(i + 1)) begin errs++; $display("FAIL seq_next%0d: strb=%b pc=%0d ret=%0d want 110000/%0d/%0d", i, strb, pc, retired, i + 1, i + 1); end
    end
  endtask

  task automatic test_redirect_wrap();
    run_instr(1'b1, 6'd10, 1'b1, 6'd20);
    #1;
    cmps++; if (pc !== 6'd10 || retired !== 16'd4) begin errs++; $display("FAIL jump_prio: pc=%0d ret=%0d want 10/4", pc, retired); end
    run_instr(1'b0, 6'd10, 1'b1, 6'd20);
    #1;
    cmps++; if (pc !== 6'd20 || retired !== 16'd5) begin errs++; $display("FAIL branch: pc=%0d ret=%0d want 20/5", pc, retired); end
    run_instr(1'b1, 6'd63, 1'b0, 6'd0);
    #1;
    cmps++; if (pc !== 6'd63 || retired !== 16'd6) begin errs++; $display("FAIL jump63: pc=%0d ret=%0d want 63/6", pc, retired); end
    run_instr(1'b0, 6'd0, 1'b0, 6'd0);
    #1;
    cmps++; if (pc !== 6'd0 || retired !== 16'd7) begin errs++; $display("FAIL pc_wrap: pc=%0d ret=%0d want 0/7", pc, retired); end
  endtask

  task automatic test_wait_states();
    imem_ready = 1'b0;
    #1;
    cmps++; if (strb !== 6'b100000) begin errs++; $display("FAIL fetch_wait1: strb=%b want 100000", strb); end
    step();
    cmps++; if (strb !== 6'b100000 || pc !== 6'd0) begin errs++; $display("FAIL fetch_wait2: strb=%b pc=%0d want 100000/0", strb, pc); end
    step();
    cmps++; if (strb !== 6'b100000) begin errs++; $display("FAIL fetch_wait3: strb=%b want 100000", strb); end
    step();
    imem_ready = 1'b1;
    #1;
    cmps++; if (strb !== 6'b110000) begin errs++; $display("FAIL fetch_ready: strb=%b want 110000", strb); end
    step();
    alu_busy = 1'b1;
    #1;
    cmps++; if (strb !== 6'b001000) begin errs++; $display("FAIL wait_decode: strb=%b want 001000", strb); end
    step();
    cmps++; if (strb !== 6'b000100) begin errs++; $display("FAIL busy1: strb=%b want 000100", strb); end
    step();
    cmps++; if (strb !== 6'b000100) begin errs++; $display("FAIL busy2: strb=%b want 000100", strb); end
    step();
    alu_busy = 1'b0;
    #1;
    cmps++; if (strb !== 6'b000100) begin errs++; $display("FAIL busy3: strb=%b want 000100", strb); end
    step();
    cmps++; if (strb !== 6'b000010) begin errs++; $display("FAIL wait_wb: strb=%b want 000010", strb); end
    step();
    cmps++; if (strb !== 6'b110000 || pc !== 6'd1 || retired !== 16'd8) begin errs++; $display("FAIL wait_next: strb=%b pc=%0d ret=%0d want 110000/1/8", strb, pc, retired); end
  endtask

  task automatic test_halt();
    run_instr(1'b1, 6'd5, 1'b0, 6'd0);
    #1;
    cmps++; if (pc !== 6'd5 || retired !== 16'd9) begin errs++; $display("FAIL to_pc5: pc=%0d ret=%0d want 5/9", pc, retired); end
    step();
    is_halt = 1'b1;
    #1;
    cmps++; if (strb !== 6'b001000) begin errs++; $display("FAIL halt_decode: strb=%b want 001000", strb); end
    step();
    is_halt = 1'b0;
    #1;
    cmps++; if (strb !== 6'b000001 || pc !== 6'd5 || retired !== 16'd9) begin errs++; $display("FAIL halted: strb=%b pc=%0d ret=%0d want 000001/5/9", strb, pc, retired); end
    stall = 1'b1;
    #1;
    cmps++; if (strb !== 6'b000001) begin errs++; $display("FAIL halted_stall: strb=%b want 000001", strb); end
    stall = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    #1;
    cmps++; if (strb !== 6'b110000 || pc !== 6'd0 || retired !== 16'd9) begin errs++; $display("FAIL restart: strb=%b pc=%0d ret=%0d want 110000/0/9", strb, pc, retired); end
  endtask

  task automatic test_stall_reset();
    stall = 1'b1;
    #1;
    cmps++; if (strb !== 6'b000000) begin errs++; $display("FAIL stall_fetch: strb=%b want 000000", strb); end
    step();
    cmps++; if (strb !== 6'b000000 || pc !== 6'd0) begin errs++; $display("FAIL stall_fetch_hold: strb=%b pc=%0d want 000000/0", strb, pc); end
    stall = 1'b0;
    #1;
    cmps++; if (strb !== 6'b110000) begin errs++; $display("FAIL unstall_fetch: strb=%b want 110000", strb); end
    step();
    step();
    stall = 1'b1; start = 1'b1;
    #1;
    cmps++; if (strb !== 6'b000000) begin errs++; $display("FAIL stall_exec1: strb=%b want 000000", strb); end
    step();
    cmps++; if (strb !== 6'b000000 || pc !== 6'd0 || retired !== 16'd9) begin errs++; $display("FAIL stall_exec2: strb=%b pc=%0d ret=%0d want 000000/0/9", strb, pc, retired); end
    step();
    stall = 1'b0; start = 1'b0;
    #1;
    cmps++; if (strb !== 6'b000100) begin errs++; $display("FAIL exec_frozen: strb=%b want 000100", strb); end
    step();
    cmps++; if (strb !== 6'b000010) begin errs++; $display("FAIL stall_wb: strb=%b want 000010", strb); end
    rst = 1'b0;
    #1;
    cmps++; if (strb !== 6'b000000 || pc !== 6'd0 || retired !== 16'd0) begin errs++; $display("FAIL mid_wb_reset: strb=%b pc=%0d ret=%0d want 000000/0/0", strb, pc, retired); end
    step();
    @(negedge clk); rst = 1'b1;
    step();
    cmps++; if (strb !== 6'b000000 || pc !== 6'd0) begin errs++; $display("FAIL post_reset_idle: strb=%b pc=%0d want 000000/0", strb, pc); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_redirect_wrap();
    test_wait_states();
    test_halt();
    test_stall_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end

endmodule
